// File: rtl/uart_auto_load_ctrl.sv
// Framed UART auto-load sequencer: sync byte, 16-bit word count, MSB-first payload, XOR checksum, ACK/NAK reply.
// Each word reaches the load port one cycle after its last byte; the reply byte waits for tx_busy to clear.
module uart_auto_load_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'h5A,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              load_abort,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic              auto_load_en,
  input  logic              data_to_load_valid,
  input  logic [7:0]        data_to_load,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int          BYTES     = DATA_W / 8;
  localparam int          BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int          WI_W      = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CHK,
    S_RESP_DROP,
    S_RESP_SEND
  } state_t;

  state_t            state, state_d;
  logic [15:0]       len;
  logic [15:0]       n_len;
  logic [7:0]        chk;
  logic [BC_W-1:0]   byte_cnt;
  logic [WI_W-1:0]   word_idx;
  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_nxt;
  logic [23:0]       tmo_cnt;
  logic              resp_nak;
  logic              mem_we_q;

  logic counting;
  logic timed_out;
  logic last_byte;
  logic last_word;
  logic to_drop;
  logic nak_d;
  logic wr_word;
  logic sync_hit;
  logic send;

  assign n_len     = {len[15:8], data_to_load};
  assign word_nxt  = (word_reg << 8) | DATA_W'(data_to_load);
  assign last_byte = (byte_cnt == BC_W'(BYTES - 1));
  assign last_word = (word_idx == WI_W'(len - 16'd1));
  assign counting  = (state == S_LEN_H) || (state == S_LEN_L) ||
                     (state == S_PAYLOAD) || (state == S_CHK);
  // A byte arriving in the final cycle of the window still counts as on time.
  assign timed_out = counting && !data_to_load_valid && (tmo_cnt >= TIMEOUT_CYC - 24'd1);

  always_comb begin
    state_d  = state;
    to_drop  = 1'b0;
    nak_d    = 1'b0;
    wr_word  = 1'b0;
    sync_hit = 1'b0;
    send     = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_req) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (data_to_load_valid && (data_to_load == SYNC_BYTE)) begin
          state_d  = S_LEN_H;
          sync_hit = 1'b1;
        end
      end
      S_LEN_H: begin
        if (data_to_load_valid) begin
          state_d = S_LEN_L;
        end else if (timed_out) begin
          to_drop = 1'b1;
          nak_d   = 1'b1;
        end
      end
      S_LEN_L: begin
        if (data_to_load_valid) begin
          if ((n_len == 16'd0) || (32'(n_len) > MAX_WORDS)) begin
            to_drop = 1'b1;
            nak_d   = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else if (timed_out) begin
          to_drop = 1'b1;
          nak_d   = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (data_to_load_valid) begin
          if (last_byte) begin
            wr_word = 1'b1;
            if (last_word) state_d = S_CHK;
          end
        end else if (timed_out) begin
          to_drop = 1'b1;
          nak_d   = 1'b1;
        end
      end
      S_CHK: begin
        if (data_to_load_valid) begin
          to_drop = 1'b1;
          nak_d   = (data_to_load != chk);
        end else if (timed_out) begin
          to_drop = 1'b1;
          nak_d   = 1'b1;
        end
      end
      S_RESP_DROP: begin
        state_d = S_RESP_SEND;
      end
      S_RESP_SEND: begin
        if (!tx_busy) begin
          send    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (to_drop) state_d = S_RESP_DROP;
    if (load_abort) begin
      state_d  = S_IDLE;
      to_drop  = 1'b0;
      wr_word  = 1'b0;
      sync_hit = 1'b0;
      send     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      chk       <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      word_reg  <= '0;
      tmo_cnt   <= '0;
      resp_nak  <= 1'b0;
      tx_data   <= '0;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state    <= state_d;
      mem_we_q <= wr_word;

      if ((state_d != state) || data_to_load_valid) begin
        tmo_cnt <= '0;
      end else if (counting) begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end

      if (sync_hit) begin
        len      <= '0;
        chk      <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
      end

      if (data_to_load_valid && (state == S_LEN_H)) begin
        len[15:8] <= data_to_load;
        chk       <= chk ^ data_to_load;
      end

      if (data_to_load_valid && (state == S_LEN_L)) begin
        len[7:0] <= data_to_load;
        chk      <= chk ^ data_to_load;
      end

      if (data_to_load_valid && (state == S_PAYLOAD)) begin
        word_reg <= word_nxt;
        chk      <= chk ^ data_to_load;
        if (last_byte) begin
          byte_cnt <= '0;
          word_idx <= word_idx + WI_W'(1);
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end

      if (wr_word) begin
        mem_addr  <= word_idx[ADDR_W-1:0];
        mem_wdata <= word_nxt;
      end

      if (to_drop) begin
        resp_nak <= nak_d;
        tx_data  <= nak_d ? NAK_BYTE : ACK_BYTE;
      end
    end
  end

  assign load_busy    = (state != S_IDLE);
  assign auto_load_en = counting || (state == S_SYNC);
  assign tx_start     = send;
  assign load_done    = send && !resp_nak;
  assign load_err     = send && resp_nak;
  // An abort landing on the strobe cycle kills the write as well.
  assign mem_we       = mem_we_q && !load_abort;

endmodule

// File: tb/tb_uart_auto_load_ctrl.sv
// Directed bench for uart_auto_load_ctrl: framed sessions, error replies, timeout, abort and async reset.
module tb_uart_auto_load_ctrl;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 12;
  localparam logic [23:0] TMO    = 24'd200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic              load_abort = 1'b0;
  logic              load_busy, load_done, load_err, auto_load_en;
  logic              data_to_load_valid = 1'b0;
  logic [7:0]        data_to_load = 8'h00;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              xmit_busy = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // The wrapper forces tx_busy while it routes rx bytes to the loader.
  assign tx_busy = xmit_busy | auto_load_en;

  uart_auto_load_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .load_abort(load_abort),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .auto_load_en(auto_load_en), .data_to_load_valid(data_to_load_valid),
    .data_to_load(data_to_load), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int n_wr = 0, n_tx = 0, n_done = 0, n_err = 0;
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [DATA_W-1:0] wr_data [0:63];
  logic [7:0]        last_tx = 8'h00;
  logic              aen_at_tx = 1'b1;
  int b_wr, b_tx, b_done, b_err;

  always @(negedge clk) begin
    if (mem_we && n_wr < 64) begin
      wr_addr[n_wr] = mem_addr;
      wr_data[n_wr] = mem_wdata;
    end
    if (mem_we) n_wr++;
    if (tx_start) begin
      n_tx++;
      last_tx   = tx_data;
      aen_at_tx = auto_load_en;
    end
    if (load_done) n_done++;
    if (load_err) n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_wr = n_wr; b_tx = n_tx; b_done = n_done; b_err = n_err;
  endtask

  task automatic req();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 data_to_load_valid = 1'b1; data_to_load = b;
    @(posedge clk); #1 data_to_load_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q [$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (load_busy && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, {63'd0, load_busy}, 64'd0);
  endtask

  task automatic expect_session(input string tag, input int wr, input logic [7:0] resp);
    check({tag, "_writes"}, 64'(n_wr - b_wr), 64'(wr));
    check({tag, "_tx_cnt"}, 64'(n_tx - b_tx), 64'd1);
    check({tag, "_tx_data"}, 64'(last_tx), 64'(resp));
    check({tag, "_done"}, 64'(n_done - b_done), (resp == 8'h06) ? 64'd1 : 64'd0);
    check({tag, "_err"}, 64'(n_err - b_err), (resp == 8'h15) ? 64'd1 : 64'd0);
    check({tag, "_aen_at_tx"}, {63'd0, aen_at_tx}, 64'd0);
  endtask

  // Checksum of the good frame: 00^02 ^ 11^22^33^44 ^ AA^BB^CC^DD = 02^44^00 = 46.
  logic [7:0] good [$];
  logic [7:0] fr [$];
  int cyc;

  initial begin
    #400_000;
    $display("FAIL watchdog busy=%0b", load_busy);
    $fatal(1, "watchdog expired");
  end

  initial begin
    good = {8'h5A, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};

    @(negedge clk);
    check("rst_busy", {63'd0, load_busy}, 64'd0);
    check("rst_aen", {63'd0, auto_load_en}, 64'd0);
    check("rst_outs", {60'd0, tx_start, load_done, load_err, mem_we}, 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_mem", {20'd0, mem_addr, mem_wdata}, 64'd0);
    #2 rst = 1'b0;

    // T1: good two-word frame
    snap();
    req();
    @(negedge clk);
    check("t1_busy", {62'd0, load_busy, auto_load_en}, 64'd3);
    send_seq(good);
    wait_idle("t1_idle", 50, cyc);
    expect_session("t1", 2, 8'h06);
    check("t1_addr0", 64'(wr_addr[b_wr]), 64'd0);
    check("t1_data0", 64'(wr_data[b_wr]), 64'h11223344);
    check("t1_addr1", 64'(wr_addr[b_wr+1]), 64'd1);
    check("t1_data1", 64'(wr_data[b_wr+1]), 64'hAABBCCDD);
    check("t1_tx_hold", 64'(tx_data), 64'h06);

    // T2: bad checksum, words still written
    snap();
    fr = good;
    fr[11] = 8'h03;
    req();
    send_seq(fr);
    wait_idle("t2_idle", 50, cyc);
    expect_session("t2", 2, 8'h15);
    check("t2_data1", 64'(wr_data[b_wr+1]), 64'hAABBCCDD);

    // T3: junk before sync, zero length
    snap();
    req();
    send_seq({8'h00, 8'hFF});
    @(negedge clk);
    check("t3_still_sync", {62'd0, load_busy, auto_load_en}, 64'd3);
    send_seq({8'h5A, 8'h00, 8'h00});
    wait_idle("t3_idle", 50, cyc);
    expect_session("t3", 0, 8'h15);

    // Length one past the memory size
    snap();
    req();
    send_seq({8'h5A, 8'h10, 8'h01});
    wait_idle("len_max_idle", 50, cyc);
    expect_session("len_max", 0, 8'h15);

    // T4: inter-byte timeout in the middle of a word
    snap();
    req();
    send_seq({8'h5A, 8'h00, 8'h01, 8'h11, 8'h22});
    wait_idle("t4_idle", 400, cyc);
    check("t4_window", {63'd0, (cyc >= 190 && cyc <= 215)}, 64'd1);
    expect_session("t4", 0, 8'h15);

    // T5: abort mid-payload, then a fresh session
    snap();
    req();
    send_seq({8'h5A, 8'h00, 8'h02, 8'h11, 8'h22});
    @(posedge clk); #1 load_abort = 1'b1;
    @(posedge clk); #1 load_abort = 1'b0;
    @(negedge clk);
    check("t5_idle", {62'd0, load_busy, auto_load_en}, 64'd0);
    repeat (5) @(negedge clk);
    check("t5_quiet", 64'((n_tx - b_tx) + (n_done - b_done) + (n_err - b_err) + (n_wr - b_wr)), 64'd0);
    snap();
    req();
    send_seq(good);
    wait_idle("t5_new_idle", 50, cyc);
    expect_session("t5_new", 2, 8'h06);

    // Abort on the last byte of a word suppresses that write
    snap();
    req();
    send_seq({8'h5A, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33});
    @(posedge clk); #1 data_to_load_valid = 1'b1; data_to_load = 8'h44; load_abort = 1'b1;
    @(posedge clk); #1 data_to_load_valid = 1'b0; load_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_wr", 64'(n_wr - b_wr), 64'd0);
    check("abort_busy", {63'd0, load_busy}, 64'd0);

    // Abort beats a simultaneous request in IDLE
    @(posedge clk); #1 load_req = 1'b1; load_abort = 1'b1;
    @(posedge clk); #1 load_req = 1'b0; load_abort = 1'b0;
    @(negedge clk);
    check("req_abort_idle", {63'd0, load_busy}, 64'd0);

    // T6: async reset mid-payload after one word landed
    req();
    send_seq({8'h5A, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t6_rst_ctl", {61'd0, load_busy, auto_load_en, mem_we}, 64'd0);
    check("t6_rst_mem", {20'd0, mem_addr, mem_wdata}, 64'd0);
    check("t6_rst_tx", 64'(tx_data), 64'd0);
    @(negedge clk); rst = 1'b0;

    // T6: transmitter busy stalls the reply
    snap();
    xmit_busy = 1'b1;
    req();
    send_seq(good);
    repeat (20) @(negedge clk);
    check("t6_stall_tx", 64'(n_tx - b_tx), 64'd0);
    check("t6_stall_busy", {62'd0, load_busy, auto_load_en}, 64'd2);
    @(posedge clk); #1 xmit_busy = 1'b0;
    wait_idle("t6_idle", 20, cyc);
    expect_session("t6", 2, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
